// File: rtl/pipectl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard/sequencing controller.
// Holds register-address width, FSM encoding and the saturating-counter helper.
package pipectl_pkg;

   localparam int REGADDRSIZE     = 5;
   localparam int PIPECTL_FSMSIZE = 2;

   typedef enum logic [PIPECTL_FSMSIZE-1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pipectl_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/pipectl_hazdetect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. XZR never creates a hazard.
module pipectl_hazdetect
   import pipectl_pkg::*;
#(
   parameter int ZEROREG = 31
) (
   input  logic                   idexmemread,
   input  logic [REGADDRSIZE-1:0] idexrd,
   input  logic [REGADDRSIZE-1:0] ifidrn,
   input  logic [REGADDRSIZE-1:0] ifidrm,
   input  logic                   ifidusesrn,
   input  logic                   ifidusesrm,
   output logic                   hazard
);

   logic rn_match;
   logic rm_match;

   assign rn_match = ifidusesrn && (ifidrn == idexrd);
   assign rm_match = ifidusesrm && (ifidrm == idexrd);
   assign hazard   = idexmemread && (idexrd != REGADDRSIZE'(ZEROREG)) && (rn_match || rm_match);

endmodule

// File: rtl/pipectl.sv
// Hazard and sequencing controller for the five-stage LEGv8 pipeline: fill, stalls,
// branch flushes, memory-wait freeze, halt and watchdog. Macro PIPECTL_PERF_EN adds perf counters.
module pipectl
   import pipectl_pkg::*;
#(
   parameter int FILLCYCLES = 4,
   parameter int MEMTIMEOUT = 255,
   parameter int ZEROREG    = 31
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   idexmemread,
   input  logic [REGADDRSIZE-1:0] idexrd,
   input  logic [REGADDRSIZE-1:0] ifidrn,
   input  logic [REGADDRSIZE-1:0] ifidrm,
   input  logic                   ifidusesrn,
   input  logic                   ifidusesrm,
   input  logic                   exmembranchtaken,
   input  logic                   exmemhalt,
   input  logic                   dmembusy,
   output logic                   pcwrite,
   output logic                   pcsrc,
   output logic                   ifidwrite,
   output logic                   ifidflush,
   output logic                   idexwrite,
   output logic                   idexflush,
   output logic                   exmemwrite,
   output logic                   exmemflush,
   output logic                   memwbflush,
   output logic                   halted,
   output logic                   memerr
`ifdef PIPECTL_PERF_EN
  ,output logic [31:0]            stallcount,
   output logic [31:0]            flushcount,
   output logic [31:0]            waitcount
`endif
);

   localparam int FILLW = (FILLCYCLES > 2) ? $clog2(FILLCYCLES) : 1;
   localparam logic [FILLW-1:0] FILL_LAST = FILLW'((FILLCYCLES > 0) ? FILLCYCLES - 1 : 0);

   pipectl_state_e   state_q, state_d;
   logic [FILLW-1:0] fill_cnt_q, fill_cnt_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d, wait_inc;
   logic             memerr_q, memerr_d;
   logic             hazard;
   logic             stall_ev, flush_ev, wait_ev;

   pipectl_hazdetect #(.ZEROREG(ZEROREG)) u_hazdetect (
      .idexmemread (idexmemread),
      .idexrd      (idexrd),
      .ifidrn      (ifidrn),
      .ifidrm      (ifidrm),
      .ifidusesrn  (ifidusesrn),
      .ifidusesrm  (ifidusesrm),
      .hazard      (hazard)
   );

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      pcwrite    = 1'b0;
      pcsrc      = 1'b0;
      ifidwrite  = 1'b0;
      idexwrite  = 1'b0;
      exmemwrite = 1'b0;
      ifidflush  = 1'b0;
      idexflush  = 1'b0;
      exmemflush = 1'b0;
      memwbflush = 1'b0;
      halted     = 1'b0;
      stall_ev   = 1'b0;
      flush_ev   = 1'b0;
      wait_ev    = 1'b0;
      case (state_q)
         FILL: begin
            ifidflush  = 1'b1;
            idexflush  = 1'b1;
            exmemflush = 1'b1;
            memwbflush = 1'b1;
            if ((FILLCYCLES == 0) || (fill_cnt_q == FILL_LAST)) state_d = RUN;
            else fill_cnt_d = fill_cnt_q + FILLW'(1);
         end
         RUN: begin
            pcwrite    = 1'b1;
            ifidwrite  = 1'b1;
            idexwrite  = 1'b1;
            exmemwrite = 1'b1;
            // EX/MEM is held during a wait, so lower-priority events retry once busy drops
            if (dmembusy) begin
               pcwrite    = 1'b0;
               ifidwrite  = 1'b0;
               idexwrite  = 1'b0;
               exmemwrite = 1'b0;
               memwbflush = 1'b1;
               wait_ev    = 1'b1;
            end else if (exmemhalt) begin
               pcwrite    = 1'b0;
               ifidflush  = 1'b1;
               idexflush  = 1'b1;
               exmemflush = 1'b1;
               state_d    = HALTED;
            end else if (exmembranchtaken) begin
               pcsrc      = 1'b1;
               ifidflush  = 1'b1;
               idexflush  = 1'b1;
               exmemflush = 1'b1;
               flush_ev   = 1'b1;
            end else if (hazard) begin
               pcwrite    = 1'b0;
               ifidwrite  = 1'b0;
               idexflush  = 1'b1;
               stall_ev   = 1'b1;
            end
         end
         HALTED: halted = 1'b1;
         default: state_d = FILL;
      endcase
   end

   assign wait_inc   = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
   assign wait_cnt_d = wait_ev ? wait_inc : 8'd0;
   assign memerr_d   = memerr_q || (wait_ev && (int'(wait_inc) >= MEMTIMEOUT));
   assign memerr     = memerr_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= FILL;
         fill_cnt_q <= '0;
         wait_cnt_q <= '0;
         memerr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         memerr_q   <= memerr_d;
      end
   end

`ifdef PIPECTL_PERF_EN
   logic [31:0] stallcount_q, flushcount_q, waitcount_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stallcount_q <= '0;
         flushcount_q <= '0;
         waitcount_q  <= '0;
      end else begin
         stallcount_q <= sat_inc32(stallcount_q, stall_ev);
         flushcount_q <= sat_inc32(flushcount_q, flush_ev);
         waitcount_q  <= sat_inc32(waitcount_q, wait_ev);
      end
   end

   assign stallcount = stallcount_q;
   assign flushcount = flushcount_q;
   assign waitcount  = waitcount_q;
`endif

endmodule

// File: tb/tb_pipectl.sv
// Directed bench for pipectl: fill, load-use, branch, memory wait, watchdog, halt and reset abort.
// Control outputs are packed as {pcwrite,pcsrc,ifidwrite,ifidflush,idexwrite,idexflush,exmemwrite,exmemflush,memwbflush,halted,memerr}.
module tb_pipectl;
   import pipectl_pkg::*;

   localparam logic [10:0] V_FILL   = 11'b00010101100;
   localparam logic [10:0] V_IDLE   = 11'b10101010000;
   localparam logic [10:0] V_STALL  = 11'b00001110000;
   localparam logic [10:0] V_BRANCH = 11'b11111111000;
   localparam logic [10:0] V_FREEZE = 11'b00000000100;
   localparam logic [10:0] V_HALTNG = 11'b00111111000;
   localparam logic [10:0] V_HALTED = 11'b00000000010;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic idexmemread = 1'b0;
   logic [REGADDRSIZE-1:0] idexrd = '0;
   logic [REGADDRSIZE-1:0] ifidrn = '0;
   logic [REGADDRSIZE-1:0] ifidrm = '0;
   logic ifidusesrn = 1'b0;
   logic ifidusesrm = 1'b0;
   logic exmembranchtaken = 1'b0;
   logic exmemhalt = 1'b0;
   logic dmembusy = 1'b0;
   logic pcwrite, pcsrc, ifidwrite, ifidflush, idexwrite, idexflush;
   logic exmemwrite, exmemflush, memwbflush, halted, memerr;
   logic [10:0] ctl_vec;
`ifdef PIPECTL_PERF_EN
   logic [31:0] stallcount, flushcount, waitcount;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipectl #(.FILLCYCLES(4), .MEMTIMEOUT(10), .ZEROREG(31)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .idexmemread      (idexmemread),
      .idexrd           (idexrd),
      .ifidrn           (ifidrn),
      .ifidrm           (ifidrm),
      .ifidusesrn       (ifidusesrn),
      .ifidusesrm       (ifidusesrm),
      .exmembranchtaken (exmembranchtaken),
      .exmemhalt        (exmemhalt),
      .dmembusy         (dmembusy),
      .pcwrite          (pcwrite),
      .pcsrc            (pcsrc),
      .ifidwrite        (ifidwrite),
      .ifidflush        (ifidflush),
      .idexwrite        (idexwrite),
      .idexflush        (idexflush),
      .exmemwrite       (exmemwrite),
      .exmemflush       (exmemflush),
      .memwbflush       (memwbflush),
      .halted           (halted),
      .memerr           (memerr)
`ifdef PIPECTL_PERF_EN
     ,.stallcount       (stallcount),
      .flushcount       (flushcount),
      .waitcount        (waitcount)
`endif
   );

   assign ctl_vec = {pcwrite, pcsrc, ifidwrite, ifidflush, idexwrite, idexflush,
                     exmemwrite, exmemflush, memwbflush, halted, memerr};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held, then released away from the clock edge
      repeat (2) @(posedge clk);
      #1;
      check("reset", 32'(ctl_vec), 32'(V_FILL));
      rstn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         #1;
         check($sformatf("fill_edge%0d", i), 32'(ctl_vec), 32'((i < 4) ? V_FILL : V_IDLE));
      end

      // load-use on rn, then the two non-hazard cases, then rm
      idexmemread = 1'b1; idexrd = 5'd5; ifidrn = 5'd5; ifidusesrn = 1'b1;
      #1 check("lu_rn", 32'(ctl_vec), 32'(V_STALL));
      cyc();
      idexrd = 5'd31; ifidrn = 5'd31;
      #1 check("lu_xzr", 32'(ctl_vec), 32'(V_IDLE));
      cyc();
      idexrd = 5'd5; ifidrn = 5'd5; ifidusesrn = 1'b0;
      #1 check("lu_nouse", 32'(ctl_vec), 32'(V_IDLE));
      cyc();
      ifidrm = 5'd5; ifidusesrm = 1'b1;
      #1 check("lu_rm", 32'(ctl_vec), 32'(V_STALL));
      cyc();

      // branch overrides load-use
      exmembranchtaken = 1'b1;
      #1 check("br_lu", 32'(ctl_vec), 32'(V_BRANCH));
      cyc();

      // memory wait freezes everything, branch resolves when busy drops
      dmembusy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("busy_br%0d", i), 32'(ctl_vec), 32'(V_FREEZE));
         cyc();
      end
      dmembusy = 1'b0; idexmemread = 1'b0;
      #1 check("br_after_busy", 32'(ctl_vec), 32'(V_BRANCH));
      cyc();

      // watchdog: memerr appears after the 10th busy edge
      exmembranchtaken = 1'b0; dmembusy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1 check($sformatf("wd%0d", k), 32'(ctl_vec), 32'(V_FREEZE | ((k >= 10) ? 11'd1 : 11'd0)));
         cyc();
      end
      dmembusy = 1'b0;
      #1 check("memerr_sticky0", 32'(ctl_vec), 32'(V_IDLE | 11'd1));
      cyc();
      #1 check("memerr_sticky1", 32'(ctl_vec), 32'(V_IDLE | 11'd1));

      // halt, then inputs ignored
      exmemhalt = 1'b1;
      #1 check("halting", 32'(ctl_vec), 32'(V_HALTNG | 11'd1));
      cyc();
      #1 check("halted", 32'(ctl_vec), 32'(V_HALTED | 11'd1));
      dmembusy = 1'b1; exmembranchtaken = 1'b1; idexmemread = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1 check($sformatf("halt_hold%0d", i), 32'(ctl_vec), 32'(V_HALTED | 11'd1));
      end
`ifdef PIPECTL_PERF_EN
      check("stallcount", stallcount, 32'd2);
      check("flushcount", flushcount, 32'd2);
      check("waitcount", waitcount, 32'd15);
`endif

      // asynchronous reset aborts immediately and clears memerr
      rstn = 1'b0;
      #1 check("rst_abort", 32'(ctl_vec), 32'(V_FILL));
`ifdef PIPECTL_PERF_EN
      check("perf_rst", stallcount | flushcount | waitcount, 32'd0);
`endif
      dmembusy = 1'b0; exmembranchtaken = 1'b0; idexmemread = 1'b0; exmemhalt = 1'b0;
      cyc();
      rstn = 1'b1;
      repeat (4) cyc();
      #1 check("rerun", 32'(ctl_vec), 32'(V_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipectl.md
Name: pipectl

Overview:
- Hazard and sequencing controller for the five-stage pipelined LEGv8 core.
- Drives the write-enable and flush (bubble) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branches resolved in MEM, data-memory wait states and halt.
- Sequences the post-reset pipeline fill and provides a memory-wait watchdog.

Parameters:
- FILLCYCLES, 4: cycles after reset release during which all pipeline registers are flushed and PC is held.
- MEMTIMEOUT, 255: maximum consecutive dmembusy cycles before memerr asserts; 8-bit counter.
- ZEROREG, 31: register number of XZR; never creates a hazard.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- idexmemread  in  1  instruction in EX is a load (LDUR family)
- idexrd  in  `REGADDRSIZE  destination of instruction in EX
- ifidrn  in  `REGADDRSIZE  first source of instruction in ID
- ifidrm  in  `REGADDRSIZE  second source of instruction in ID
- ifidusesrn  in  1  ID instruction reads rn
- ifidusesrm  in  1  ID instruction reads rm
- exmembranchtaken  in  1  branch in MEM resolved taken
- exmemhalt  in  1  HALT opcode in MEM
- dmembusy  in  1  data memory not ready this cycle
- pcwrite  out  1  PC update enable
- pcsrc  out  1  1 selects EX/MEM branch target
- ifidwrite  out  1
- ifidflush  out  1
- idexwrite  out  1
- idexflush  out  1  zero ID/EX control (bubble)
- exmemwrite  out  1
- exmemflush  out  1  zero EX/MEM control
- memwbflush  out  1  zero MEM/WB control
- halted  out  1
- memerr  out  1  sticky watchdog error

Behaviour:
- FSM states: FILL, RUN, HALTED. Async reset (rstn=0) enters FILL and clears the fill counter, the wait counter and memerr.
- Reset output values: pcwrite=0, pcsrc=0, all write enables=0, all flushes=1, halted=0, memerr=0.
- FILL: hold PC and assert all flushes. After FILLCYCLES rising edges with rstn=1, enter RUN. FILLCYCLES=0 enters RUN on the first edge.
- RUN, default: all writes=1, all flushes=0, pcsrc=0.
- RUN outputs are combinational (Mealy) from the current state and inputs, and resolve the same cycle.
- RUN conditions, highest priority first:
  1. dmembusy: freeze. pcwrite, ifidwrite, idexwrite and exmemwrite are 0. memwbflush=1. Branch, halt and load-use are ignored this cycle and re-evaluated when busy drops, because EX/MEM is held.
  2. exmemhalt: pcwrite=0, ifidflush=1, idexflush=1, exmemflush=1. Enter HALTED on the edge.
  3. exmembranchtaken: pcsrc=1, pcwrite=1, ifidflush=1, idexflush=1, exmemflush=1 (3-cycle penalty).
  4. Load-use: idexmemread and idexrd!=ZEROREG and ((ifidusesrn and ifidrn==idexrd) or (ifidusesrm and ifidrm==idexrd)). Outputs pcwrite=0, ifidwrite=0, idexflush=1, giving exactly one bubble.
- HALTED: all writes 0, all flushes 0, halted=1. Only reset leaves this state.
- Watchdog: the 8-bit wait counter increments while dmembusy=1 in RUN and clears when dmembusy=0. When it reaches MEMTIMEOUT, memerr latches to 1. memerr is sticky until reset and saturates without wrapping. memerr does not alter the freeze behaviour.
- Reset asserted mid-stall or mid-flush aborts immediately to reset values.

Optional Feature:
- Macro PIPECTL_PERF_EN.
- Defined: adds outputs stallcount, flushcount and waitcount, each 32 bits, reset to 0.
  - stallcount increments on each load-use bubble.
  - flushcount increments on each taken-branch flush.
  - waitcount increments on each dmembusy cycle in RUN.
  - All three saturate at all-ones and freeze in HALTED.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- bus.vh: REGADDRSIZE is already there; add PIPECTL_FSMSIZE and the state encodings FILL=0, RUN=1, HALTED=2.
- Sub-module hazdetect: the purely combinational load-use comparator (idexmemread, idexrd, ifid sources and use bits in; hazard out). It is reused by a planned forwarding unit.

Test Plan:
- Reset/fill: rstn low, then released. Expect all flushes=1 and pcwrite=0 for exactly 4 edges, then RUN with all writes=1.
- Load-use: idexmemread=1, idexrd=5, ifidrn=5, ifidusesrn=1. Expect one cycle with pcwrite=0, ifidwrite=0, idexflush=1. With idexrd=31 or ifidusesrn=0, no stall.
- Taken branch concurrent with load-use: exmembranchtaken=1 and a hazard present. Expect pcsrc=1, flushes on IF/ID, ID/EX and EX/MEM, and no pcwrite hold.
- Memory wait with branch: dmembusy=1 for 3 cycles alongside exmembranchtaken=1. Expect a full freeze with memwbflush=1, then the branch flush in the cycle busy drops.
- Watchdog: MEMTIMEOUT=10, dmembusy held for 12 cycles. Expect memerr rising after the 10th cycle and staying high after busy drops until rstn=0.
- Halt: exmemhalt=1. Expect halted=1 next cycle, all enables 0, and inputs ignored thereafter. With PIPECTL_PERF_EN, counters read their final values unchanged.
